// File: rtl/mul_unit_seq.sv
// Iterative shift-add multiply / multiply-accumulate (MUL, MLA, UMULL, UMLAL, SMULL, SMLAL).
// Latency: WIDTH+2 cycles busy, done pulses after FIX; backpressure: start ignored while busy, flush aborts.
module mul_unit_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             flag_n,
    output logic             flag_z
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [W2-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [W2-1:0]    prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic             flag_n_q, flag_n_d, flag_z_q, flag_z_d;

    logic             sgn_long;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [W2-1:0]    fix_prod, acc_ext, fix_sum;

    assign sgn_long = op[2] & op[1];
    // Magnitudes are unsigned, so the most-negative operand maps to 2^(W-1) without overflow.
    assign a_abs    = a[WIDTH-1] ? -a : a;
    assign b_abs    = b[WIDTH-1] ? -b : b;

    always_comb begin
        fix_prod = (op_q[2] & op_q[1] & sign_q) ? -prod_q : prod_q;
        acc_ext  = '0;
        if (op_q[0]) begin
            acc_ext = op_q[2] ? {acc_hi_q, acc_lo_q} : {{WIDTH{1'b0}}, acc_lo_q};
        end
        fix_sum = fix_prod + acc_ext;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d     = op;
                    mcand_d  = {{WIDTH{1'b0}}, (sgn_long ? a_abs : a)};
                    mplier_d = sgn_long ? b_abs : b;
                    sign_d   = sgn_long & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_hi_d = acc_hi;
                    acc_lo_d = acc_lo;
                    prod_d   = '0;
                    cnt_d    = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (mplier_q[0]) begin
                        prod_d = prod_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q[2]) begin
                        res_hi_d = fix_sum[W2-1:WIDTH];
                        res_lo_d = fix_sum[WIDTH-1:0];
                        flag_n_d = fix_sum[W2-1];
                        flag_z_d = (fix_sum == '0);
                    end else begin
                        res_hi_d = '0;
                        res_lo_d = fix_sum[WIDTH-1:0];
                        flag_n_d = fix_sum[WIDTH-1];
                        flag_z_d = (fix_sum[WIDTH-1:0] == '0);
                    end
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign res_hi = res_hi_q;
    assign res_lo = res_lo_q;
    assign flag_n = flag_n_q;
    assign flag_z = flag_z_q;

endmodule

// File: tb/tb_mul_unit_seq.sv
// Bench for mul_unit_seq: directed and random operations checked against an arithmetic reference.
module tb_mul_unit_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, flush, busy, done, flag_n, flag_z;
    logic [2:0]  op;
    logic [31:0] a, b, acc_hi, acc_lo, res_hi, res_lo;

    logic        start8, flush8, busy8, done8, flag_n8, flag_z8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, acc_hi8, acc_lo8, res_hi8, res_lo8;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] last_res;
    logic        last_n, last_z;

    mul_unit_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
        .a(a), .b(b), .acc_hi(acc_hi), .acc_lo(acc_lo),
        .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo),
        .flag_n(flag_n), .flag_z(flag_z)
    );

    mul_unit_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .flush(flush8), .op(op8),
        .a(a8), .b(b8), .acc_hi(acc_hi8), .acc_lo(acc_lo8),
        .busy(busy8), .done(done8), .res_hi(res_hi8), .res_lo(res_lo8),
        .flag_n(flag_n8), .flag_z(flag_z8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: full-precision product of the operands as the op interprets them.
    function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                            input logic [31:0] ah, input logic [31:0] al);
        logic signed [63:0] sx, sy;
        logic [63:0]        p;
        logic [63:0]        lo;
        if (o[2]) begin
            if (o[1]) begin
                sx = {{32{x[31]}}, x};
                sy = {{32{y[31]}}, y};
                p  = sx * sy;
            end else begin
                p = {32'b0, x} * {32'b0, y};
            end
            if (o[0]) p = p + {ah, al};
            return p;
        end
        lo = {32'b0, x} * {32'b0, y};
        if (o[0]) lo = lo + {32'b0, al};
        return {32'b0, lo[31:0]};
    endfunction

    task automatic run32(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ah, input logic [31:0] al, input bit disturb);
        logic [63:0] e;
        logic        en, ez, busy_ok;
        int          n;
        e  = ref_res(o, x, y, ah, al);
        en = o[2] ? e[63] : e[31];
        ez = o[2] ? (e == 64'd0) : (e[31:0] == 32'd0);
        op = o; a = x; b = y; acc_hi = ah; acc_lo = al; start = 1'b1;
        tick();
        start   = 1'b0;
        n       = 1;
        busy_ok = 1'b1;
        while (!done && n < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (disturb && n == 3) begin
                start = 1'b1; op = 3'b111; a = ~x; b = ~y; acc_hi = ~ah; acc_lo = ~al;
            end
            if (n == 6) start = 1'b0;
            tick();
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd34);
        chk({tag, " busy"}, {63'd0, busy_ok & busy}, 64'd1);
        chk({tag, " result"}, {res_hi, res_lo}, e);
        chk({tag, " flags"}, {62'd0, flag_n, flag_z}, {62'd0, en, ez});
        tick();
        chk({tag, " idle_after"}, {res_hi, res_lo, 29'd0, busy, done, flag_n}, {e, 29'd0, 1'b0, 1'b0, en});
        last_res = e; last_n = en; last_z = ez;
    endtask

    initial begin
        int  n;
        bit  saw_done;
        reset = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; acc_hi = '0; acc_lo = '0;
        start8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; acc_hi8 = '0; acc_lo8 = '0;
        last_res = '0; last_n = 1'b0; last_z = 1'b0;
        #12;
        chk("reset_state", {res_hi, res_lo, 28'd0, busy, done, flag_n, flag_z}, 96'd0);
        reset = 1'b1;
        tick();

        run32("umull_ones", 3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0);
        chk("umull_ones_const", last_res, 64'hFFFFFFFE_00000001);
        run32("smull_m1", 3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0);
        chk("smull_m1_const", last_res, 64'h00000000_00000001);
        run32("smull_min2", 3'b110, 32'h80000000, 32'd2, 32'h0, 32'h0, 1'b0);
        chk("smull_min2_const", last_res, 64'hFFFFFFFF_00000000);
        run32("smull_minmin", 3'b110, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 1'b0);
        run32("mla", 3'b001, 32'd3, 32'd5, 32'h0, 32'd7, 1'b0);
        chk("mla_const", last_res, 64'd22);
        run32("mul_wrap", 3'b000, 32'h10000, 32'h10000, 32'h0, 32'h0, 1'b0);
        chk("mul_wrap_z", {63'd0, last_z}, 64'd1);
        run32("umlal_wrap", 3'b101, 32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        chk("umlal_wrap_const", last_res, 64'd0);
        run32("smlal", 3'b111, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd10, 1'b0);
        chk("smlal_const", last_res, 64'd4);
        run32("start_ignored", 3'b100, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0, 1'b1);

        for (int i = 0; i < 16; i++) begin
            run32("random", 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom, 1'b0);
        end

        // Abort at cnt=10: no done, previous result held.
        op = 3'b100; a = $urandom; b = $urandom; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle", {63'd0, busy}, 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        chk("flush_no_done", {63'd0, saw_done}, 64'd0);
        chk("flush_hold", {res_hi, res_lo}, last_res);
        chk("flush_hold_flags", {62'd0, flag_n, flag_z}, {62'd0, last_n, last_z});

        flush = 1'b1; start = 1'b1;
        tick();
        flush = 1'b0; start = 1'b0;
        chk("flush_start_idle", {63'd0, busy}, 64'd0);

        run32("pre_reset", 3'b100, 32'hFFFFFFFF, 32'h3, 32'h0, 32'h0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        #1;
        chk("reset_midcalc", {res_hi, res_lo, 28'd0, busy, done, flag_n, flag_z}, 96'd0);
        #2;
        reset = 1'b1;
        tick();
        chk("reset_release_idle", {62'd0, busy, done}, 64'd0);

        op8 = 3'b110; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 50) begin
            tick();
            n++;
        end
        chk("w8_latency", 64'(n), 64'd10);
        chk("w8_result", {48'd0, res_hi8, res_lo8}, 64'h4000);
        chk("w8_flags", {62'd0, flag_n8, flag_z8}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mul_unit_seq.md
Name: mul_unit_seq

Overview:
- Parametrised iterative multiply/multiply-accumulate unit for the multicycle core.
- Executes MUL, MLA, UMULL, UMLAL, SMULL and SMLAL using a shift-add datapath, one multiplier bit per cycle.
- Driven by the main FSM through a start/busy/done handshake.
- Replaces the single-cycle combinational multiply ALU path, adds accumulate modes, and produces N/Z flags for the flag logic.

Parameters:
WIDTH, 32, operand width in bits; long results are 2*WIDTH bits; legal range 4..64.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request operation; sampled only in IDLE
flush  input  1  synchronous abort; returns to IDLE without done
op  input  3  op[2]=long, op[1]=signed (meaningful only when long), op[0]=accumulate
a  input  WIDTH  multiplicand (Rn/Rm per decoder)
b  input  WIDTH  multiplier
acc_hi  input  WIDTH  accumulate high word (long accumulate only)
acc_lo  input  WIDTH  accumulate low word
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse; results valid this cycle
res_hi  output  WIDTH  result high word; 0 for short ops
res_lo  output  WIDTH  result low word
flag_n  output  1  negative flag of the result
flag_z  output  1  zero flag of the result

Behaviour:
- Reset (reset=0, async): state=IDLE; busy, done, res_hi, res_lo, flag_n, flag_z, counter and internal registers all 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On an edge with start=1, latch op, a, b, acc_hi, acc_lo.
  - If op[2]&op[1] (signed long), latch |a| and |b| and record sign = a[W-1]^b[W-1]; otherwise latch the raw operands.
  - Clear the 2W-bit product register, set cnt=0, go to CALC.
- CALC:
  - Each edge: if the current multiplier LSB is 1, add the multiplicand (shifted by cnt) into the product; shift the multiplier right; cnt++.
  - After WIDTH CALC edges (cnt==WIDTH-1 processed), go to FIX.
- FIX (one edge):
  - If signed long and sign=1, negate the 2W-bit product (two's complement).
  - Then add the accumulator if op[0]: long adds {acc_hi,acc_lo} mod 2^(2W); short adds acc_lo mod 2^W.
  - Load res_hi/res_lo. Short ops: res_hi=0, res_lo = low W bits.
  - Compute flags:
    - flag_n = long ? res_hi[W-1] : res_lo[W-1].
    - flag_z = long ? ({res_hi,res_lo}==0) : (res_lo==0).
  - Go to DONE.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE.
- Latency: start edge at cycle 0 gives done high during the cycle after edge WIDTH+2, i.e. busy for WIDTH+2 cycles. WIDTH=32: done follows the 34th edge.
- res_*/flag_* are registered and hold their values after done until the next FIX; they are not disturbed by CALC.
- Unsigned long and short ops ignore op[1]. Short results are identical for signed and unsigned operands (low word only).
- Signed corner: a = b = most-negative value. |x| is taken as an unsigned W-bit value (2^(W-1)), so the product is correct; no overflow indication.
- Simultaneous and abort events:
  - start while busy: ignored, with no effect on latched operands.
  - flush=1: from CALC/FIX go to IDLE next edge, with no done and res_* unchanged; in DONE, flush suppresses nothing (done already asserted); flush in IDLE has no effect.
  - flush and start on the same edge in IDLE: flush wins, and the unit stays IDLE.
  - Reset mid-operation: immediate IDLE, all outputs 0.
- No combinational path from inputs to outputs.

Test Plan:
- UMULL (op=100), WIDTH=32, a=b=0xFFFFFFFF -> done pulses after 34 edges; res_hi=0xFFFFFFFE, res_lo=0x00000001, flag_n=1, flag_z=0; busy high throughout, low after.
- SMULL (op=110): a=0xFFFFFFFF, b=0xFFFFFFFF -> res=0x00000000_00000001. Then a=0x80000000, b=2 -> res_hi=0xFFFFFFFF, res_lo=0x00000000, flag_n=1.
- MLA (op=001): a=3, b=5, acc_lo=7 -> res_lo=22, res_hi=0, flags 0/0. Then MUL a=0x10000, b=0x10000 -> res_lo=0, flag_z=1.
- UMLAL (op=101): a=1, b=1, acc={0xFFFFFFFF,0xFFFFFFFF} -> res=0 (wrap), flag_z=1. Then SMLAL a=-2, b=3, acc=10 -> res=4.
- Handshake: start re-asserted during CALC with different operands -> first result unchanged. flush at CALC cnt=10 -> IDLE next edge, no done, res_* hold the previous result. reset pulse low mid-CALC -> all outputs 0 immediately.
- WIDTH=8 instance: SMULL a=0x80, b=0x80 -> done after 10 edges, res_hi=0x40, res_lo=0x00, flag_n=0.
